// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read port; master is the UART drain that pops, slave is the FIFO.
interface fifo_uart_tx_if #(parameter int f_WIDTH = 8);
  logic RD_EN;
  logic f_empty;
  logic [f_WIDTH-1:0] f_data;
  modport master (output RD_EN, input f_empty, f_data);
  modport slave (input RD_EN, output f_empty, f_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the FIFO one word at a time onto a UART line (start, data LSB-first, stop).
// UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int f_WIDTH = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic asyn_rst_n,
  input  logic tx_en,
  fifo_uart_tx_if.master fifo,
  output logic tx,
  output logic busy,
  output logic [f_WIDTH-1:0] frame_cnt
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(f_WIDTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(f_WIDTH - 1);
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state;
  logic [CW-1:0] baud;
  logic [IW-1:0] idx;
  logic [f_WIDTH-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  logic bit_end;
  assign bit_end = baud == BAUD_LAST;
  // Every serial state leaves on bit_end, so the baud counter is zero on each state entry.
  always_ff @(posedge clk or negedge asyn_rst_n) begin
    if (!asyn_rst_n) begin
      state <= IDLE;
      baud <= '0;
      idx <= '0;
      shreg <= '0;
      tx <= 1'b1;
      fifo.RD_EN <= 1'b0;
      busy <= 1'b0;
      frame_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      baud <= (bit_end || state inside {IDLE, FETCH, LOAD}) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (tx_en && !fifo.f_empty) begin
          state <= FETCH;
          fifo.RD_EN <= 1'b1;
          busy <= 1'b1;
        end
        FETCH: begin
          fifo.RD_EN <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          shreg <= fifo.f_data;
`ifdef UART_TX_PARITY_EN
          par <= ^fifo.f_data;
`endif
          tx <= 1'b0;
          state <= START;
        end
        START: if (bit_end) begin
          tx <= shreg[0];
          idx <= '0;
          state <= DATA;
        end
        DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          if (idx == IDX_LAST) begin
            idx <= '0;
`ifdef UART_TX_PARITY_EN
            tx <= par;
            state <= PARITY;
`else
            tx <= 1'b1;
            state <= STOP;
`endif
          end else begin
            idx <= idx + 1'b1;
            tx <= shreg[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          tx <= 1'b1;
          state <= STOP;
        end
`endif
        STOP: if (bit_end) begin
          busy <= 1'b0;
          frame_cnt <= frame_cnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: table-driven and randomized frame checks against a bit-level waveform model.
module tb_fifo_uart_tx;
  localparam int W = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  localparam int FRAME = NB * CPB;
  logic clk = 1'b0;
  logic asyn_rst_n = 1'b0;
  logic tx_en = 1'b0;
  logic tx, busy;
  logic [W-1:0] frame_cnt;
  fifo_uart_tx_if #(.f_WIDTH(W)) fifo ();
  fifo_uart_tx #(.f_WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .asyn_rst_n(asyn_rst_n), .tx_en(tx_en), .fifo(fifo.master),
    .tx(tx), .busy(busy), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  logic [W-1:0] mem [0:255];
  int wp = 0;
  int rp = 0;
  int cyc = 0;
  assign fifo.f_empty = (wp == rp);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo.RD_EN) begin
      fifo.f_data <= mem[rp[7:0]];
      rp <= rp + 1;
    end
  end
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int last_rd = 0;
  typedef struct {
    logic [W-1:0] data;
    logic [10:0] wave;
  } vec_t;
  vec_t vt [7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [W-1:0] d);
    mem[wp[7:0]] = d;
    wp++;
  endtask
  function automatic logic [10:0] model(input logic [W-1:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction
  task automatic expect_frame(input logic [10:0] w, input string tag, input int drop_bit, input int gap);
    int t;
    logic b;
    logic [2:0] got;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!fifo.RD_EN && t < 300);
    chk($sformatf("%s pop", tag), fifo.RD_EN, 1);
    if (fifo.RD_EN !== 1'b1) return;
    chk($sformatf("%s fetch busy/tx", tag), {busy, tx}, 2'b11);
    if (gap > 0) chk($sformatf("%s pop spacing", tag), cyc - last_rd, gap);
    last_rd = cyc;
    @(negedge clk);
    chk($sformatf("%s load rd/tx", tag), {fifo.RD_EN, tx}, 2'b01);
    for (int i = 0; i < NB; i++) begin
      b = (i == NB - 1) ? w[10] : w[i];
      got = {1'b1, 1'b0, b};
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (i == drop_bit && c == 0) tx_en = 1'b0;
        if ({busy, fifo.RD_EN, tx} !== {1'b1, 1'b0, b}) got = {busy, fifo.RD_EN, tx};
      end
      chk($sformatf("%s bit%0d busy/rd/tx", tag, i), got, {1'b1, 1'b0, b});
    end
    @(negedge clk);
    exp_cnt++;
    chk($sformatf("%s end busy/tx/cnt", tag), {busy, tx, frame_cnt}, {1'b0, 1'b1, 8'(exp_cnt)});
  endtask
  task automatic no_pop(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (fifo.RD_EN !== 1'b0) seen = 1'b1;
    end
    chk($sformatf("%s no pop", tag), seen, 0);
  endtask
  initial begin
    logic [W-1:0] rq [4];
    int n, t;
    vt[0] = '{8'hAA, 11'b1_0_10101010_0};
    vt[1] = '{8'h11, 11'b1_0_00010001_0};
    vt[2] = '{8'h22, 11'b1_0_00100010_0};
    vt[3] = '{8'h33, 11'b1_0_00110011_0};
    vt[4] = '{8'hC4, 11'b1_1_11000100_0};
    vt[5] = '{8'h07, 11'b1_1_00000111_0};
    vt[6] = '{8'h5A, 11'b1_0_01011010_0};
    tx_en = 1'b1;
    push(vt[0].data);
    repeat (5) begin
      @(negedge clk);
      chk("reset hold", {tx, fifo.RD_EN, busy, frame_cnt}, {1'b1, 1'b0, 1'b0, 8'h00});
    end
    asyn_rst_n = 1'b1;
    expect_frame(vt[0].wave, "single AA", -1, 0);
    no_pop(20, "single AA idle");
    for (int i = 1; i <= 3; i++) push(vt[i].data);
    for (int i = 1; i <= 3; i++) expect_frame(vt[i].wave, $sformatf("burst%0d", i), -1, i > 1 ? FRAME + 3 : 0);
    no_pop(60, "burst empty");
    push(vt[4].data);
    push(vt[5].data);
    expect_frame(vt[4].wave, "gate C4", 3, 0);
    no_pop(100, "gated");
    tx_en = 1'b1;
    expect_frame(vt[5].wave, "gate 07", -1, 0);
    no_pop(20, "after gate");
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        rq[k] = W'($urandom);
        push(rq[k]);
      end
      for (int k = 0; k < n; k++)
        expect_frame(model(rq[k]), $sformatf("rand%0d.%0d", r, k), -1, k > 0 ? FRAME + 3 : 0);
      no_pop(10, $sformatf("rand%0d idle", r));
    end
    push(8'h00);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!fifo.RD_EN && t < 300);
    chk("midreset pop", fifo.RD_EN, 1);
    repeat (1 + CPB + 3 * CPB + 1) @(negedge clk);
    chk("midreset bit3 tx", tx, 0);
    #1 asyn_rst_n = 1'b0;
    #1 chk("midreset async", {tx, fifo.RD_EN, busy, frame_cnt}, {1'b1, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    asyn_rst_n = 1'b1;
    exp_cnt = 0;
    no_pop(60, "midreset release");
    chk("midreset cnt", frame_cnt, 0);
    push(vt[6].data);
    expect_frame(vt[6].wave, "post reset 5A", -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
